md5_hit_collector: RTL
======================

# md5_hit_collector

Consumer end of the guess-to-hash stream in the MD5 cracker. Delays each issued guess to align with its digest at the MD5 pipeline output, compares the digest against the 128-bit target, and queues every matching guess in a small FIFO for the host via valid/ready. It also tracks in-flight guesses so `done` rises only after the generator has finished and the pipeline has fully drained.

## Interface
Parameters:
- `PIPE_LAT`, 64: cycles from `guess_valid` sampled to the matching digest on `hashA..D`; legal range 1–255.
- `HIT_DEPTH`, 4: hit FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous restart; empties pipeline tracking and FIFO, zeroes counters and flags.
- `guess_valid`  in  1  guess issued to the MD5 pipeline this cycle.
- `guess`  in  128  guess issued this cycle.
- `gen_done`  in  1  generator exhausted; level, sampled each cycle.
- `hashA`, `hashB`, `hashC`, `hashD`  in  32 each  digest words from the pipeline.
- `targetA`, `targetB`, `targetC`, `targetD`  in  32 each  target digest; static during a run.
- `hit`  out  1  sticky: at least one match since reset/clear.
- `hit_valid`  out  1  FIFO head valid.
- `hit_guess`  out  128  FIFO head guess.
- `hit_ready`  in  1  host accepts head when `hit_valid && hit_ready`.
- `hit_count`  out  16  matches found, saturating at 16'hFFFF.
- `overflow`  out  1  sticky: a match was dropped because the FIFO was full.
- `done`  out  1  search complete and drained.

## Operation
- Alignment: `PIPE_LAT`-deep shift register of {valid, guess}; stage 0 loads `guess_valid`/`guess` each cycle. The tap at depth `PIPE_LAT` aligns with `hashA..D` in the same cycle.
- Compare: `match = tap_valid && {hashA,hashB,hashC,hashD} == {targetA,targetB,targetC,targetD}`; registered one cycle (compare stage).
- On registered match:
  - push the aligned guess into the FIFO;
  - set `hit`;
  - increment `hit_count` (saturating).
- FIFO full on push:
  - with a simultaneous pop, push is accepted;
  - otherwise the match is dropped and `overflow` is set. `hit_count` still increments.
- Pop when `hit_valid && hit_ready`. `hit_ready` while empty has no effect.
- FSM:
  - RUN → DRAIN when `gen_done` = 1. The drain counter loads `PIPE_LAT+1`. `guess_valid` is ignored in DRAIN and DONE.
  - DRAIN → DONE when the drain counter reaches 0.
  - DONE holds until `clear` or reset. `done` = 1 only in DONE.
- `clear` (any state) → RUN, with:
  - shift-register valid bits and compare register zeroed;
  - FIFO pointers zeroed;
  - `hit`, `overflow`, `hit_count` zeroed;
  - `clear` wins over any simultaneous push/pop.
- Async reset has the same effect as `clear` and is applied immediately. Guess data bits need no reset; valid bits do.

## Timing
- Reset values:
  - `hit` = 0, `hit_valid` = 0, `hit_count` = 0, `overflow` = 0, `done` = 0;
  - `hit_guess` = 0 (FIFO storage reset);
  - FSM = RUN.
- A guess sampled at cycle t is compared at t+`PIPE_LAT`. FIFO write occurs at the edge ending t+`PIPE_LAT`+1; `hit_valid`/`hit_guess` are visible from cycle t+`PIPE_LAT`+2. `hit` and `hit_count` update at the same edge.
- `gen_done` first sampled high at cycle g: DRAIN spans cycles g+1 … g+`PIPE_LAT`+1; `done` = 1 from cycle g+`PIPE_LAT`+2. The last guess (≤ g) has therefore left the compare stage.
- FIFO show-ahead: `hit_guess` is valid whenever `hit_valid` = 1 and stays stable until popped.
- Back-to-back matches are sustained at one per cycle while the FIFO has room.

## Structure
- Shared package `md5crack_pkg`:
  - `GUESS_W` = 128, `HASH_W` = 128;
  - FSM state enum {RUN, DRAIN, DONE};
  - `HIT_CNT_W` = 16.
- Sub-module `hit_fifo`: synchronous, show-ahead, parameterised width/depth, with full/empty flags and the push-when-full-with-pop rule. Alignment line, compare, counters and FSM live in the top.

## Test plan
- `PIPE_LAT`=4; target = MD5("ab"); stream 10 guesses with "ab" at index 3 (cycle 3) → `hit_valid` rises at cycle 9 with `hit_guess`="ab" padded; `hit_count`=1; `hit`=1.
- Matches on 6 consecutive cycles, `HIT_DEPTH`=4, `hit_ready`=0 → 4 entries held, `overflow`=1, `hit_count`=6; then `hit_ready`=1 → 4 pops in order, `hit_valid`=0.
- FIFO full, `hit_ready`=1 at the same cycle a match arrives → push accepted, `overflow` stays 0, order preserved.
- `gen_done` high at cycle 20 with `PIPE_LAT`=4 → `done`=0 through cycle 25, `done`=1 at cycle 26; a match on a guess issued at cycle 20 is still captured.
- `reset_n` pulsed low mid-DRAIN between clock edges → all outputs 0 immediately; after release, FSM is in RUN and a new match is detected normally.
- `clear` asserted the same cycle as a push and a pop → FIFO empty, `hit_count`=0, `hit`=0 the next cycle.

Source files
------------

// File: rtl/md5crack_pkg.sv
// Shared widths and FSM state type for the MD5 cracker datapath.
package md5crack_pkg;

    localparam int GUESS_W   = 128;
    localparam int HASH_W    = 128;
    localparam int HIT_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/md5_hit_collector_if.sv
// Hit stream from the collector to the host: show-ahead valid/ready with the matching guess.
interface md5_hit_collector_if;
    import md5crack_pkg::*;

    logic               hit_valid;
    logic [GUESS_W-1:0] hit_guess;
    logic               hit_ready;

    modport master (output hit_valid, output hit_guess, input hit_ready);
    modport slave  (input hit_valid, input hit_guess, output hit_ready);

endinterface

// File: rtl/md5_hit_collector_fifo.sv
// Small show-ahead FIFO for matching guesses; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module hit_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is reset so the head reads zero out of reset; clear only moves the pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/md5_hit_collector.sv
// Aligns issued guesses with MD5 pipeline digests, queues matches for the host and
// raises done once the generator has finished and the pipeline has drained.
module md5_hit_collector
    import md5crack_pkg::*;
#(
    parameter int PIPE_LAT  = 64,
    parameter int HIT_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  guess_valid,
    input  logic [GUESS_W-1:0]    guess,
    input  logic                  gen_done,
    input  logic [31:0]           hashA,
    input  logic [31:0]           hashB,
    input  logic [31:0]           hashC,
    input  logic [31:0]           hashD,
    input  logic [31:0]           targetA,
    input  logic [31:0]           targetB,
    input  logic [31:0]           targetC,
    input  logic [31:0]           targetD,
    output logic                  hit,
    md5_hit_collector_if.master   hit_if,
    output logic [HIT_CNT_W-1:0]  hit_count,
    output logic                  overflow,
    output logic                  done
);
    localparam logic [8:0]           DRAIN_LOAD = 9'(PIPE_LAT + 1);
    localparam logic [HIT_CNT_W-1:0] CNT_ONE    = HIT_CNT_W'(1);

    state_t             state;
    logic [8:0]         drain_cnt;
    logic [PIPE_LAT-1:0] line_valid;
    logic [GUESS_W-1:0] line_guess [PIPE_LAT];
    logic [HASH_W-1:0]  digest;
    logic [HASH_W-1:0]  target;
    logic               match_q;
    logic [GUESS_W-1:0] match_guess;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    assign digest           = {hashA, hashB, hashC, hashD};
    assign target           = {targetA, targetB, targetC, targetD};
    assign pop              = !fifo_empty && hit_if.hit_ready;
    assign hit_if.hit_valid = !fifo_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_valid <= '0;
            match_q    <= 1'b0;
        end else if (clear) begin
            line_valid <= '0;
            match_q    <= 1'b0;
        end else begin
            line_valid[0] <= guess_valid && (state == RUN);
            for (int i = 1; i < PIPE_LAT; i++) line_valid[i] <= line_valid[i-1];
            match_q <= line_valid[PIPE_LAT-1] && (digest == target);
        end
    end

    // Guess bits travel beside their valid bit and are qualified by it, so they carry no reset.
    always_ff @(posedge clk) begin
        line_guess[0] <= guess;
        for (int i = 1; i < PIPE_LAT; i++) line_guess[i] <= line_guess[i-1];
        match_guess <= line_guess[PIPE_LAT-1];
    end

    hit_fifo #(
        .WIDTH (GUESS_W),
        .DEPTH (HIT_DEPTH)
    ) u_hit_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (match_q),
        .push_data (match_guess),
        .pop       (pop),
        .head      (hit_if.hit_guess),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit       <= 1'b0;
            hit_count <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            hit       <= 1'b0;
            hit_count <= '0;
            overflow  <= 1'b0;
        end else if (match_q) begin
            hit <= 1'b1;
            if (hit_count != '1) hit_count <= hit_count + CNT_ONE;
            if (fifo_full && !pop) overflow <= 1'b1;
        end
    end

    // Drain covers PIPE_LAT+1 cycles so the last accepted guess clears the compare stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else if (clear) begin
            state     <= RUN;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (gen_done) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - 9'd1;
                    if (drain_cnt == 9'd1) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE:    done  <= 1'b1;
                default: state <= RUN;
            endcase
        end
    end

endmodule
